// File: rtl/de_decode_queue.sv
// Decode-stage instruction queue: circular FIFO of fetched instructions whose head is
// presented unpacked into MIPS fields with branch/jump classification and delay-slot tracking.

`ifndef B_EQNE
`define B_EQNE 3'd0
`endif
`ifndef B_LTGE
`define B_LTGE 3'd1
`endif
`ifndef B_JUMP
`define B_JUMP 3'd2
`endif
`ifndef B_JREG
`define B_JREG 3'd3
`endif
`ifndef B_INVA
`define B_INVA 3'd4
`endif

module de_decode_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   in_count,
    input  logic [31:0]                        in_pc,
    input  logic [32*FETCH_WIDTH-1:0]          in_instr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_pc,
    output logic [31:0]                        out_instr,
    output logic [5:0]                         opcode,
    output logic [4:0]                         rs,
    output logic [4:0]                         rt,
    output logic [4:0]                         rd,
    output logic [4:0]                         shamt,
    output logic [5:0]                         funct,
    output logic [15:0]                        immed,
    output logic [25:0]                        instr_index,
    output logic [2:0]                         branch_type,
    output logic                               is_branch_instr,
    output logic                               is_branch_link,
    output logic                               is_delay_slot,
    output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ds_pending;
    logic          push;
    logic          pop;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    // in_ready looks only at the registered count so a same-cycle pop never frees space early
    assign in_ready  = (DEPTH - int'(count)) >= FETCH_WIDTH;
    assign out_valid = (count != '0);
    assign occupancy = count;
    assign push      = in_valid && in_ready && (in_count != '0) && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k < int'(in_count)) begin
                    mem_instr[wr_ptr + PW'(k)] <= in_instr[32*k +: 32];
                    mem_pc[wr_ptr + PW'(k)]    <= in_pc + 32'(4*k);
                end
            end
        end
    end

    // Flush wins over any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= wr_ptr;
            count      <= '0;
            ds_pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(in_count);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                ds_pending <= is_branch_instr;
            end
            count <= count + (push ? CW'(in_count) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        end
    end

    // Empty queue decodes as an all-zero instruction at PC 0
    assign head_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
    assign head_pc    = out_valid ? mem_pc[rd_ptr]    : 32'h0;

    assign out_instr     = head_instr;
    assign out_pc        = head_pc;
    assign opcode        = head_instr[31:26];
    assign rs            = head_instr[25:21];
    assign rt            = head_instr[20:16];
    assign rd            = head_instr[15:11];
    assign shamt         = head_instr[10:6];
    assign funct         = head_instr[5:0];
    assign immed         = head_instr[15:0];
    assign instr_index   = head_instr[25:0];
    assign is_delay_slot = ds_pending && out_valid;

    always_comb begin
        branch_type     = `B_INVA;
        is_branch_instr = 1'b0;
        is_branch_link  = 1'b0;
        if (opcode[5:2] == 4'b0001) begin
            branch_type     = `B_EQNE;
            is_branch_instr = 1'b1;
        end else if (opcode == 6'b000001 && rt[3:1] == 3'b000) begin
            branch_type     = `B_LTGE;
            is_branch_instr = 1'b1;
            is_branch_link  = rt[4];
        end else if (opcode[5:1] == 5'b00001) begin
            branch_type     = `B_JUMP;
            is_branch_instr = 1'b1;
            is_branch_link  = opcode[0];
        end else if (opcode == 6'b000000 && funct[5:1] == 5'b00100) begin
            branch_type     = `B_JREG;
            is_branch_instr = 1'b1;
            is_branch_link  = funct[0];
        end
    end

    a_in_count_legal: assert property (@(posedge clk) disable iff (rst)
        !(in_valid && int'(in_count) > FETCH_WIDTH));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        int'(count) <= DEPTH);

endmodule

// File: tb/tb_de_decode_queue.sv
// Scoreboard bench for de_decode_queue: stimulus pushes expected head entries,
// a negedge monitor pops and compares them whenever the DUT pops its head.

module tb_de_decode_queue;

    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam logic [2:0] T_EQNE = 3'd0;
    localparam logic [2:0] T_LTGE = 3'd1;
    localparam logic [2:0] T_JUMP = 3'd2;
    localparam logic [2:0] T_JREG = 3'd3;
    localparam logic [2:0] T_INVA = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_count;
    logic [31:0] in_pc;
    logic [63:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immed;
    logic [25:0] instr_index;
    logic [2:0]  branch_type;
    logic        is_branch_instr;
    logic        is_branch_link;
    logic        is_delay_slot;
    logic [3:0]  occupancy;

    de_decode_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immed(immed), .instr_index(instr_index),
        .branch_type(branch_type), .is_branch_instr(is_branch_instr),
        .is_branch_link(is_branch_link), .is_delay_slot(is_delay_slot),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Hand-decoded instruction vectors
    logic [31:0] tbl_instr [12] = '{32'h1000_0004, 32'h0411_0003, 32'h0C00_0010, 32'h0320_F809,
                                   32'h0000_0008, 32'h0000_0000, 32'h0800_0000, 32'h0000_0020,
                                   32'h0401_0005, 32'h0412_0000, 32'h1C00_0000, 32'h8C00_0000};
    logic [2:0]  tbl_bt [12]    = '{T_EQNE, T_LTGE, T_JUMP, T_JREG, T_JREG, T_INVA,
                                   T_JUMP, T_INVA, T_LTGE, T_INVA, T_EQNE, T_INVA};
    logic        tbl_br [12]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tbl_lk [12]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  bt;
        logic        br;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_count = 0;
    logic model_ds = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input int idx);
        exp_t e;
        e.pc    = pc;
        e.instr = tbl_instr[idx];
        e.bt    = tbl_bt[idx];
        e.br    = tbl_br[idx];
        e.lk    = tbl_lk[idx];
        return e;
    endfunction

    // One clock of stimulus; checks registered status against the bench's count model
    task automatic cycle(input logic v, input int cnt, input logic [31:0] pc,
                         input int i0, input int i1, input logic rdy, input logic fl);
        bit acc;
        bit pp;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_count  = cnt[1:0];
        in_pc     = pc;
        in_instr  = {tbl_instr[i1], tbl_instr[i0]};
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, (DEPTH - model_count) >= FW});
        check("occupancy", {28'd0, occupancy}, model_count);
        check("out_valid", {31'd0, out_valid}, {31'd0, model_count != 0});
        acc = v && ((DEPTH - model_count) >= FW) && (cnt != 0) && !fl;
        pp  = (model_count != 0) && rdy && !fl;
        if (acc) begin
            sb.push_back(mk(pc, i0));
            if (cnt == 2) sb.push_back(mk(pc + 32'd4, i1));
        end
        if (fl) model_count = 0;
        else    model_count = model_count + (acc ? cnt : 0) - (pp ? 1 : 0);
    endtask

    // Monitor: compare the head against the scoreboard whenever it is consumed
    always @(negedge clk) begin
        if (rst) begin
            model_ds = 1'b0;
        end else if (flush) begin
            sb.delete();
            model_ds = 1'b0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_empty: out_valid=1 pc=%h but no entry expected", out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_pc", out_pc, e.pc);
                check("pop_instr", out_instr, e.instr);
                check("pop_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
                check("pop_rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, e.instr[25:11]});
                check("pop_shamt_funct", {21'd0, shamt, funct}, {21'd0, e.instr[10:0]});
                check("pop_immed", {16'd0, immed}, {16'd0, e.instr[15:0]});
                check("pop_instr_index", {6'd0, instr_index}, {6'd0, e.instr[25:0]});
                check("pop_branch_type", {29'd0, branch_type}, {29'd0, e.bt});
                check("pop_is_branch", {31'd0, is_branch_instr}, {31'd0, e.br});
                check("pop_link", {31'd0, is_branch_link}, {31'd0, e.lk});
                check("pop_delay_slot", {31'd0, is_delay_slot}, {31'd0, model_ds});
                model_ds = e.br;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = 2'd0;
        in_pc = 32'h0; in_instr = 64'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occupancy", {28'd0, occupancy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_delay_slot", {31'd0, is_delay_slot}, 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_branch_type", {29'd0, branch_type}, {29'd0, T_INVA});
        check("rst_branch_flags", {30'd0, is_branch_instr, is_branch_link}, 32'd0);
        rst = 1'b0;

        // BEQ then a nop at 0x100
        cycle(1, 2, 32'h100, 0, 5, 0, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("beq_head_pc", out_pc, 32'h100);
        check("beq_branch_type", {29'd0, branch_type}, {29'd0, T_EQNE});
        check("beq_occupancy", {28'd0, occupancy}, 32'd2);
        cycle(0, 0, 32'h0, 5, 5, 1, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("ds_head_pc", out_pc, 32'h104);
        check("ds_set", {31'd0, is_delay_slot}, 32'd1);
        cycle(0, 0, 32'h0, 5, 5, 1, 0);
        cycle(1, 1, 32'h200, 7, 5, 0, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("ds_clear_pc", out_pc, 32'h200);
        check("ds_clear", {31'd0, is_delay_slot}, 32'd0);
        cycle(0, 0, 32'h0, 5, 5, 1, 0);

        // Fill to DEPTH with classification vectors
        cycle(1, 2, 32'h300, 1, 2, 0, 0);
        cycle(1, 2, 32'h308, 3, 4, 0, 0);
        cycle(1, 2, 32'h310, 0, 5, 0, 0);
        cycle(1, 2, 32'h318, 7, 6, 0, 0);
        cycle(1, 2, 32'h500, 0, 0, 0, 0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_occupancy", {28'd0, occupancy}, 32'd8);
        check("full_head_ltge", {29'd0, branch_type}, {29'd0, T_LTGE});
        cycle(1, 2, 32'h500, 0, 0, 1, 0);
        check("pop_at_full_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("occ7_in_ready", {31'd0, in_ready}, 32'd0);
        check("occ7_occupancy", {28'd0, occupancy}, 32'd7);
        repeat (4) cycle(0, 0, 32'h0, 5, 5, 1, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("after_beq_pc", out_pc, 32'h314);
        check("after_beq_ds", {31'd0, is_delay_slot}, 32'd1);

        // Push+pop+flush at occupancy 5
        cycle(1, 2, 32'h400, 2, 5, 0, 0);
        cycle(1, 2, 32'h410, 0, 0, 1, 1);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("flush_occupancy", {28'd0, occupancy}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_delay_slot", {31'd0, is_delay_slot}, 32'd0);
        cycle(1, 1, 32'h600, 5, 5, 0, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("post_flush_pc", out_pc, 32'h600);
        check("post_flush_ds", {31'd0, is_delay_slot}, 32'd0);
        cycle(0, 0, 32'h0, 5, 5, 1, 0);

        // Random traffic against the FIFO model
        for (int n = 0; n < 1000; n++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)),
                  $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 99) == 0);
        end
        for (int n = 0; n < 20 && model_count != 0; n++)
            cycle(0, 0, 32'h0, 5, 5, 1, 0);
        cycle(0, 0, 32'h0, 5, 5, 0, 0);
        check("drain_sb_empty", sb.size(), 32'd0);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
